ahb_slave_mem: RTL and testbench

//  AHB-Lite memory responder on the slave side of the bus driven by the AHB master.

---
 rtl/amba_pkg.sv | 26 ++
 rtl/ahb_slv_mem_array.sv | 20 ++
 rtl/ahb_slave_mem.sv | 97 +++++++++
 tb/tb_ahb_slave_mem.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/amba_pkg.sv
// amba_pkg: shared AHB-Lite types, bus widths and byte-lane helper for the memory slave.
package amba_pkg;
  localparam int DWIDTH = 32;
  localparam int AWIDTH = 32;
  localparam int LANES = DWIDTH / 8;
  localparam int LB = $clog2(LANES);
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ} htrans_t;
  typedef logic [2:0] hsize_t;
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;
  typedef struct packed {
    logic              hwrite;
    hsize_t            hsize;
    htrans_t           htrans;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
  } instr_t;
  // lanes lo .. lo+2**sz-1 of a word, little-endian
  function automatic logic [LANES-1:0] lane_mask(input logic [LB-1:0] lo, input hsize_t sz);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++)
      m[i] = (i >= int'(lo)) && (i < int'(lo) + (1 << int'(sz)));
    return m;
  endfunction
endpackage

// File: rtl/ahb_slv_mem_array.sv
// ahb_slv_mem_array: word RAM with byte-enable synchronous write and combinational read.
module ahb_slv_mem_array
  import amba_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [LANES-1:0]             be_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] idx_i,
  input  logic [DWIDTH-1:0]            wdata_i,
  output logic [DWIDTH-1:0]            rdata_o
);
  logic [DWIDTH-1:0] mem_q [MEM_DEPTH];
  always_ff @(posedge clk)
    if (we_i)
      for (int i = 0; i < LANES; i++)
        if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
  assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite memory slave with programmable wait states, ERROR responses
// and a one-cycle report of every committed write.
module ahb_slave_mem
  import amba_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              HSEL,
  input  logic [AWIDTH-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [1:0]        HTRANS,
  input  logic [DWIDTH-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DWIDTH-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              amba_wr_flg,
  output logic [AWIDTH-1:0] amba_slv_addr,
  output logic [DWIDTH-1:0] amba_slv_data
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [AWIDTH-1:0] LIMIT = AWIDTH'(MEM_DEPTH * LANES);
  state_t state_q, state_d;
  logic [AWIDTH-1:0] addr_q, rep_addr_q;
  logic [DWIDTH-1:0] rdata_q, rep_data_q, mem_word, merged;
  logic [3:0] wait_q;
  hsize_t size_q;
  logic write_q, wr_flg_q, accept, err, done, ready, take, we;
  logic [LANES-1:0] be;
  logic unused_ok;
  assign unused_ok = ^{HTRANS[0], addr_q[AWIDTH-1:LB+IW]};
  assign accept = HSEL & HREADY & HTRANS[1];
  assign err = (HSIZE > hsize_t'(LB)) ||
               ((HADDR & ((AWIDTH'(1) << HSIZE) - AWIDTH'(1))) != '0) ||
               (HADDR >= LIMIT);
  assign done = (state_q == S_DATA) && (wait_q >= 4'(WAIT_CYCLES));
  assign ready = (state_q == S_DATA) ? done : (state_q != S_ERR1);
  // new address phases are only taken while this slave is presenting ready
  assign take = accept & ready;
  assign we = done & write_q;
  assign be = lane_mask(addr_q[LB-1:0], size_q);
  always_comb begin
    merged = mem_word;
    for (int i = 0; i < LANES; i++)
      if (be[i]) merged[8*i +: 8] = HWDATA[8*i +: 8];
  end
  always_comb begin
    state_d = take ? (err ? S_ERR1 : S_DATA) :
              (state_q == S_ERR1) ? S_ERR2 :
              (state_q == S_DATA && !done) ? S_DATA : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      write_q <= 1'b0;
      size_q <= '0;
      wait_q <= '0;
      rdata_q <= '0;
      wr_flg_q <= 1'b0;
      rep_addr_q <= '0;
      rep_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        addr_q <= HADDR;
        write_q <= HWRITE;
        size_q <= HSIZE;
      end
      wait_q <= take ? 4'd0 : (state_q == S_DATA && !done) ? wait_q + 4'd1 : wait_q;
      if (done && !write_q) rdata_q <= mem_word;
      wr_flg_q <= we;
      if (we) begin
        rep_addr_q <= addr_q;
        rep_data_q <= merged;
      end
    end
  end
  ahb_slv_mem_array #(.MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk    (clk),
    .we_i   (we),
    .be_i   (be),
    .idx_i  (addr_q[LB +: IW]),
    .wdata_i(HWDATA),
    .rdata_o(mem_word)
  );
  assign HRDATA = (done && !write_q) ? mem_word : rdata_q;
  assign HREADYOUT = ready;
  assign HRESP = (state_q == S_ERR1 || state_q == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign amba_wr_flg = wr_flg_q;
  assign amba_slv_addr = rep_addr_q;
  assign amba_slv_data = rep_data_q;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: directed vector table over two slaves (0 and 3 wait states),
// plus hand-written back-to-back and mid-transfer reset sequences.
module tb_ahb_slave_mem;
  logic clk = 1'b0, rst_n = 1'b0;
  logic hsel = 1'b0, hwrite = 1'b0, sel_b = 1'b0;
  logic [2:0] hsize = 3'd0;
  logic [1:0] htrans = 2'd0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [31:0] rdata_a, rdata_b, faddr_a, faddr_b, fdata_a, fdata_b;
  logic rdy_a, rdy_b, resp_a, resp_b, flg_a, flg_b;
  int total = 0, bad = 0;
  logic o_resp, o_lowresp, o_flg;
  logic [31:0] o_data, o_faddr, o_fdata;
  int o_waits;

  always #5 clk = ~clk;

  ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .HSEL(hsel & ~sel_b), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(rdy_a), .HRDATA(rdata_a),
    .HREADYOUT(rdy_a), .HRESP(resp_a), .amba_wr_flg(flg_a), .amba_slv_addr(faddr_a),
    .amba_slv_data(fdata_a));
  ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .HSEL(hsel & sel_b), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(rdy_b), .HRDATA(rdata_b),
    .HREADYOUT(rdy_b), .HRESP(resp_b), .amba_wr_flg(flg_b), .amba_slv_addr(faddr_b),
    .amba_slv_data(fdata_b));

  wire rdy = sel_b ? rdy_b : rdy_a;
  wire resp = sel_b ? resp_b : resp_a;
  wire flg = sel_b ? flg_b : flg_a;
  wire [31:0] rdata = sel_b ? rdata_b : rdata_a;
  wire [31:0] faddr = sel_b ? faddr_b : faddr_a;
  wire [31:0] fdata = sel_b ? fdata_b : fdata_a;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // one NONSEQ transfer, then one idle cycle to catch the write report
  task automatic xfer(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    hsel = 1'b1; htrans = 2'd2; hwrite = w; hsize = sz; haddr = a;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'd0; hwdata = d;
    o_waits = 0;
    o_lowresp = 1'b1;
    while (!rdy && o_waits < 40) begin
      o_lowresp &= resp;
      o_waits++;
      @(negedge clk);
    end
    if (o_waits >= 40) chk("timeout", 32'(rdy), 32'd1);
    o_resp = resp;
    o_data = rdata;
    @(negedge clk);
    o_flg = flg;
    o_faddr = faddr;
    o_fdata = fdata;
  endtask

  typedef struct {
    logic b, w;
    logic [2:0] sz;
    logic [31:0] a, d;
    logic er;
    int wt;
    logic ck_rd;
    logic [31:0] rd;
    logic fl;
    logic [31:0] fd;
  } vec_t;

  vec_t v[18];

  initial begin
    v[0]  = '{0, 1, 2, 32'h000, 32'h01020304, 0, 0, 0, 32'h0,        1, 32'h01020304};
    v[1]  = '{0, 1, 2, 32'h010, 32'hDEADBEEF, 0, 0, 0, 32'h0,        1, 32'hDEADBEEF};
    v[2]  = '{0, 0, 2, 32'h010, 32'h0,        0, 0, 1, 32'hDEADBEEF, 0, 32'h0};
    v[3]  = '{0, 1, 2, 32'h010, 32'h11223344, 0, 0, 0, 32'h0,        1, 32'h11223344};
    v[4]  = '{0, 1, 0, 32'h013, 32'hAA000000, 0, 0, 0, 32'h0,        1, 32'hAA223344};
    v[5]  = '{0, 0, 2, 32'h010, 32'h0,        0, 0, 1, 32'hAA223344, 0, 32'h0};
    v[6]  = '{0, 1, 1, 32'h011, 32'hFFFFFFFF, 1, 1, 0, 32'h0,        0, 32'h0};
    v[7]  = '{0, 0, 2, 32'h010, 32'h0,        0, 0, 1, 32'hAA223344, 0, 32'h0};
    v[8]  = '{0, 1, 2, 32'h400, 32'h12345678, 1, 1, 0, 32'h0,        0, 32'h0};
    v[9]  = '{0, 0, 2, 32'h000, 32'h0,        0, 0, 1, 32'h01020304, 0, 32'h0};
    v[10] = '{0, 1, 2, 32'h014, 32'h55667788, 0, 0, 0, 32'h0,        1, 32'h55667788};
    v[11] = '{0, 1, 1, 32'h016, 32'hBEEF0000, 0, 0, 0, 32'h0,        1, 32'hBEEF7788};
    v[12] = '{0, 0, 0, 32'h015, 32'h0,        0, 0, 1, 32'hBEEF7788, 0, 32'h0};
    v[13] = '{0, 1, 3, 32'h008, 32'h0,        1, 1, 0, 32'h0,        0, 32'h0};
    v[14] = '{0, 1, 2, 32'h3FC, 32'hCAFEF00D, 0, 0, 0, 32'h0,        1, 32'hCAFEF00D};
    v[15] = '{0, 0, 2, 32'h3FC, 32'h0,        0, 0, 1, 32'hCAFEF00D, 0, 32'h0};
    v[16] = '{1, 1, 2, 32'h020, 32'h12345678, 0, 3, 0, 32'h0,        1, 32'h12345678};
    v[17] = '{1, 0, 2, 32'h020, 32'h0,        0, 3, 1, 32'h12345678, 0, 32'h0};

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy_a), 32'd1);
    chk("rst_resp", 32'(resp_a), 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_flg", 32'(flg_a), 32'd0);
    chk("rst_faddr", faddr_a, 32'd0);
    chk("rst_fdata", fdata_b, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      sel_b = v[i].b;
      xfer(v[i].w, v[i].sz, v[i].a, v[i].d);
      chk($sformatf("v%0d_resp", i), 32'(o_resp), 32'(v[i].er));
      chk($sformatf("v%0d_waits", i), 32'(o_waits), 32'(v[i].wt));
      if (v[i].wt > 0) chk($sformatf("v%0d_lowresp", i), 32'(o_lowresp), 32'(v[i].er));
      if (v[i].ck_rd) chk($sformatf("v%0d_rdata", i), o_data, v[i].rd);
      chk($sformatf("v%0d_flg", i), 32'(o_flg), 32'(v[i].fl));
      if (v[i].fl) begin
        chk($sformatf("v%0d_faddr", i), o_faddr, v[i].a);
        chk($sformatf("v%0d_fdata", i), o_fdata, v[i].fd);
      end
    end
    sel_b = 1'b0;

    // write immediately followed by a read of the same word
    @(negedge clk);
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h24;
    @(negedge clk);
    hwrite = 1'b0; hwdata = 32'h0BADCAFE;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'd0;
    chk("b2b_ready", 32'(rdy_a), 32'd1);
    chk("b2b_rdata", rdata_a, 32'h0BADCAFE);
    chk("b2b_flg", 32'(flg_a), 32'd1);
    chk("b2b_fdata", fdata_a, 32'h0BADCAFE);

    // reset during a write data phase
    @(negedge clk);
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'h99999999;
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", 32'(rdy_a), 32'd1);
    chk("mrst_resp", 32'(resp_a), 32'd0);
    chk("mrst_rdata", rdata_a, 32'd0);
    chk("mrst_flg", 32'(flg_a), 32'd0);
    chk("mrst_faddr", faddr_a, 32'd0);
    chk("mrst_fdata", fdata_a, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_noflg", 32'(flg_a), 32'd0);
    xfer(1'b0, 3'd2, 32'h10, 32'h0);
    chk("mrst_mem", o_data, 32'hAA223344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
